// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   uart_state_t    : transmitter FSM state encoding
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : serial line level when no frame is in flight
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-time generator: a CLKS_PER_BIT down-counter that pulses bit_done for one cycle
// at the end of every bit period while run is high.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   restart  : load a full bit period (asserted on the transfer edge)
//   run      : count while a frame is in flight
//   bit_done : one-cycle pulse on the last cycle of each bit
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic bit_done
);

    localparam int unsigned     CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reload on every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign bit_done = run && !restart && (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter fed directly from a FIFO read port.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   ena         : design enable; gates new transfers only
//   in_data     : byte at the FIFO head
//   in_valid    : FIFO not empty
//   in_ready    : FIFO pop strobe (combinational)
//   tx          : registered serial line, idle high
//   busy        : frame in flight
//   frames_sent : completed frame count, wraps modulo 256
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    uart_state_t               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic [7:0]                frames_q, frames_d;
    logic                      bit_done;
    logic                      transfer;
    logic                      last_bit;

    assign transfer = in_valid && in_ready;
    assign last_bit = (bit_idx_q == 3'(DATA_BITS - 1));

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (transfer),
        .run      (busy),
        .bit_done (bit_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (transfer)             state_d = START;
            START:   if (bit_done)             state_d = DATA;
            DATA:    if (bit_done && last_bit) state_d = STOP;
            STOP:    if (bit_done)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Outputs; rst_n gates in_ready so no pop is issued while reset is held.
    always_comb begin
        in_ready = (state_q == IDLE) && ena && rst_n;
        busy     = (state_q != IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            frames_q  <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            frames_q  <= frames_d;
        end
    end

    // tx is loaded one bit ahead: each bit boundary presents shift_q[0] and shifts right.
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        frames_d  = frames_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    shift_d   = in_data;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (last_bit) begin
                        tx_d = UART_IDLE_LEVEL;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    frames_d = frames_q + 8'd1;
                end
            end
            default: begin
                tx_d = UART_IDLE_LEVEL;
            end
        endcase
    end

    assign tx          = tx_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    int tests_run = 0;
    int fails = 0;
    int pops = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) pops <= pops + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd0) begin fails++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
        tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        ena = 1'b1; #1;
        tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_ena got %b want 0", in_ready); end
        rst_n = 1'b1; #1;
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [9:0] frame;
        int base;
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL single_pre_busy got %b want 0", busy); end
        in_valid = 1'b1; in_data = 8'hA5; base = pops;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            tests_run++; if (tx !== frame[c/4]) begin fails++; $display("FAIL single_tx c=%0d got %b want %b", c, tx, frame[c/4]); end
            tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy c=%0d got %b want 1", c, busy); end
        end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL single_post_busy got %b want 0", busy); end
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL single_post_tx got %b want 1", tx); end
        tests_run++; if (frames_sent !== 8'd1) begin fails++; $display("FAIL single_frames got %0d want 1", frames_sent); end
        tests_run++; if (pops - base !== 1) begin fails++; $display("FAIL single_pops got %0d want 1", pops - base); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f0;
        logic [9:0] f1;
        logic exp;
        int base;
        f0 = {1'b1, 8'h00, 1'b0};
        f1 = {1'b1, 8'hFF, 1'b0};
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h00; base = pops;
        for (int c = 1; c <= 81; c++) begin
            @(negedge clk);
            if (c == 1) in_data = 8'hFF;
            if (c == 42) in_valid = 1'b0;
            if (c <= 40) exp = f0[(c-1)/4];
            else if (c == 41) exp = 1'b1;
            else exp = f1[(c-42)/4];
            tests_run++; if (tx !== exp) begin fails++; $display("FAIL b2b_tx c=%0d got %b want %b", c, tx, exp); end
            if (c == 41) begin
                tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap_ready got %b want 1", in_ready); end
                tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap_busy got %b want 0", busy); end
            end
            if (c == 42) begin
                tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_second_busy got %b want 1", busy); end
            end
        end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_post_busy got %b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd3) begin fails++; $display("FAIL b2b_frames got %0d want 3", frames_sent); end
        tests_run++; if (pops - base !== 2) begin fails++; $display("FAIL b2b_pops got %0d want 2", pops - base); end
    endtask

    task automatic test_ena_drop();
        logic [9:0] frame;
        int base;
        frame = {1'b1, 8'h3C, 1'b0};
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C; base = pops;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 18) ena = 1'b0;
            tests_run++; if (tx !== frame[(c-1)/4]) begin fails++; $display("FAIL ena_tx c=%0d got %b want %b", c, tx, frame[(c-1)/4]); end
        end
        for (int c = 41; c <= 45; c++) begin
            @(negedge clk);
            tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ena_ready c=%0d got %b want 0", c, in_ready); end
            tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL ena_busy c=%0d got %b want 0", c, busy); end
            tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL ena_idle_tx c=%0d got %b want 1", c, tx); end
        end
        tests_run++; if (frames_sent !== 8'd4) begin fails++; $display("FAIL ena_frames got %0d want 4", frames_sent); end
        tests_run++; if (pops - base !== 1) begin fails++; $display("FAIL ena_pops_off got %0d want 1", pops - base); end
        ena = 1'b1; #1;
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ena_ready_back got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL ena_restart_busy got %b want 1", busy); end
        tests_run++; if (tx !== 1'b0) begin fails++; $display("FAIL ena_restart_tx got %b want 0", tx); end
        tests_run++; if (pops - base !== 2) begin fails++; $display("FAIL ena_pops_on got %0d want 2", pops - base); end
        repeat (40) @(negedge clk);
        tests_run++; if (frames_sent !== 8'd5) begin fails++; $display("FAIL ena_frames2 got %0d want 5", frames_sent); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] frame;
        int base;
        frame = {1'b1, 8'h96, 1'b0};
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h96; base = pops;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
        end
        // Mid bit 5 of 0x96, which is a 0, so the forced 1 is observable.
        tests_run++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_bit5_tx got %b want 0", tx); end
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_bit5_busy got %b want 1", busy); end
        rst_n = 1'b0; #1;
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_rst_tx got %b want 1", tx); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd0) begin fails++; $display("FAIL mid_rst_frames got %0d want 0", frames_sent); end
        tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0F; rst_n = 1'b1; #1;
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_release_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_first_xfer_busy got %b want 1", busy); end
        tests_run++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_first_xfer_tx got %b want 0", tx); end
        tests_run++; if (pops - base !== 2) begin fails++; $display("FAIL mid_pops got %0d want 2", pops - base); end
        repeat (40) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_done_busy got %b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd1) begin fails++; $display("FAIL mid_done_frames got %0d want 1", frames_sent); end
    endtask

    task automatic test_wrap();
        int base;
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ena = 1'b1;
        in_valid = 1'b1; in_data = 8'h55; base = pops;
        n = 0;
        while ((pops - base) < 256 && n < 256 * 41 + 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        tests_run++; if (pops - base !== 256) begin fails++; $display("FAIL wrap_pops got %0d want 256", pops - base); end
        tests_run++; if (frames_sent !== 8'd255) begin fails++; $display("FAIL wrap_frames_255 got %0d want 255", frames_sent); end
        n = 0;
        while (busy && n < 60) begin @(negedge clk); n++; end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_idle256 got busy=%b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd0) begin fails++; $display("FAIL wrap_frames_256 got %0d want 0", frames_sent); end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 60) begin @(negedge clk); n++; end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_idle257 got busy=%b want 0", busy); end
        tests_run++; if (frames_sent !== 8'd1) begin fails++; $display("FAIL wrap_frames_257 got %0d want 1", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ena_drop();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; fixed at 8 in this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  design enable; high when the tile is selected.
REQ-006 in_data  input  8  byte offered by the upstream FIFO read port.
REQ-007 in_valid  input  1  upstream FIFO non-empty; in_data is valid.
REQ-008 in_ready  output  1  this block accepts in_data this cycle (FIFO pop strobe).
REQ-009 tx  output  1  UART 8N1 serial line, idle high.
REQ-010 busy  output  1  high while a frame is being shifted out.
REQ-011 frames_sent  output  8  count of completed frames, wraps modulo 256.

Function
REQ-012 State machine SHALL have states IDLE, START, DATA, STOP.
REQ-013 in_ready SHALL be combinational: (state == IDLE) AND ena AND rst_n.
REQ-014 A transfer occurs on a rising edge with in_valid AND in_ready; in_data latched into an 8-bit shift register, state -> START.
REQ-015 in_valid without in_ready SHALL not change any state; in_data SHALL be ignored outside a transfer.
REQ-016 tx SHALL be registered; tx low from the cycle after the transfer edge (latency 1 cycle).
REQ-017 START: tx = 0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; bit index 0..7; after bit 7, STOP.
REQ-019 STOP: tx = 1 for exactly CLKS_PER_BIT cycles, then IDLE; frames_sent increments on the STOP->IDLE edge.
REQ-020 Back-to-back: with in_valid held high, the next transfer SHALL occur on the first IDLE cycle; frame period = 10*CLKS_PER_BIT + 1 cycles.
REQ-021 busy SHALL be high in START, DATA and STOP; low in IDLE.
REQ-022 ena deasserted mid-frame SHALL not abort the frame; the frame completes and no new transfer starts until ena returns high.
REQ-023 frames_sent at 255 plus a completed frame SHALL wrap to 0.
REQ-024 The bit-time counter SHALL be sized $clog2(CLKS_PER_BIT) bits and reload on every bit boundary; no off-by-one on the final bit.

Reset
REQ-025 rst_n low SHALL immediately force state = IDLE, tx = 1, busy = 0, frames_sent = 0, shift register = 0, counters = 0, in_ready = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with tx = 1 at once; no byte is re-requested; the aborted byte is lost.
REQ-027 The first transfer after reset release SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the state typedef (uart_state_t) and constants UART_DATA_BITS = 8, UART_IDLE_LEVEL = 1.
REQ-029 One sub-module, baud_tick, SHALL hold the CLKS_PER_BIT down-counter and emit a one-cycle bit_done pulse; it is restarted by the FSM on transfer.
REQ-030 The block SHALL connect directly to the FIFO read side: in_valid = FIFO not-empty, in_ready = FIFO pop.

Verification (CLKS_PER_BIT = 4)
REQ-031 Reset: rst_n low 5 cycles -> tx = 1, busy = 0, frames_sent = 0, in_ready = 0; release with ena = 1 -> in_ready = 1.
REQ-032 Single byte 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; busy high 40 cycles; frames_sent = 1.
REQ-033 Bytes 0x00, 0xFF held back-to-back -> second start bit begins 41 cycles after the first; in_ready pulses exactly twice.
REQ-034 ena dropped during DATA bit 3 of 0x3C -> frame completes intact; in_ready stays 0 until ena = 1.
REQ-035 rst_n asserted during DATA bit 5 -> tx = 1 same cycle, busy = 0, frames_sent unchanged at 0.
REQ-036 256 frames of 0x55 -> frames_sent reads 0 after frame 256 and 1 after frame 257.
